// File: rtl/riscv_instruction_encoder_if.sv
// Operation-in / machine-word-out bus of the RV32I instruction encoder.
// The master side issues operations and consumes words.
interface riscv_instruction_encoder_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  inValid;
    logic                  inReady;
    logic [4:0]            inOp;
    logic [4:0]            inRd;
    logic [4:0]            inRs1;
    logic [4:0]            inRs2;
    logic [31:0]           inImm;
    logic                  outValid;
    logic                  outReady;
    logic [31:0]           outInstruction;
    logic [ADDR_WIDTH-1:0] outAddress;
    logic                  errorFlag;

    modport master (
        output inValid, inOp, inRd, inRs1, inRs2, inImm, outReady,
        input  inReady, outValid, outInstruction, outAddress, errorFlag
    );

    modport slave (
        input  inValid, inOp, inRd, inRs1, inRs2, inImm, outReady,
        output inReady, outValid, outInstruction, outAddress, errorFlag
    );
endinterface

// File: rtl/riscv_instruction_encoder.sv
// RV32I instruction encoder: turns operations into machine words with sequential word
// addresses, expands LI into LUI+ADDI and flags illegal ops / out-of-range immediates.
module riscv_instruction_encoder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    riscv_instruction_encoder_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StLiLo} state_e;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;

    logic        in_ready, accept, xfer;
    logic [31:0] word, li_lo;
    logic [19:0] li_hi;
    logic        legal, is_li;
    logic        i_ok, b_ok, j_ok;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;

    assign xfer     = valid_q & bus.outReady;
    assign in_ready = (state_q == StIdle) & (~valid_q | bus.outReady);
    assign accept   = bus.inValid & in_ready;

    // Sign-extension checks: upper bits must all equal the sign bit of the field.
    assign i_ok = (&bus.inImm[31:11]) | ~(|bus.inImm[31:11]);
    assign b_ok = ~bus.inImm[0] & ((&bus.inImm[31:12]) | ~(|bus.inImm[31:12]));
    assign j_ok = ~bus.inImm[0] & ((&bus.inImm[31:20]) | ~(|bus.inImm[31:20]));

    // ADDI sign-extends its 12-bit immediate, so LUI pre-compensates when bit 11 is set.
    assign li_hi = bus.inImm[31:12] + {19'd0, bus.inImm[11]};
    assign li_lo = {bus.inImm[11:0], bus.inRd, 3'b000, bus.inRd, 7'b0010011};

    always_comb begin
        r_f7 = (bus.inOp == 5'd1 || bus.inOp == 5'd7) ? 7'b0100000 : 7'b0000000;
        case (bus.inOp)
            5'd0, 5'd1: r_f3 = 3'b000;
            5'd2:       r_f3 = 3'b001;
            5'd3:       r_f3 = 3'b010;
            5'd4:       r_f3 = 3'b011;
            5'd5:       r_f3 = 3'b100;
            5'd6, 5'd7: r_f3 = 3'b101;
            5'd8:       r_f3 = 3'b110;
            default:    r_f3 = 3'b111;
        endcase
    end

    always_comb begin
        word  = '0;
        legal = 1'b1;
        is_li = 1'b0;
        case (bus.inOp)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:
                word = {r_f7, bus.inRs2, bus.inRs1, r_f3, bus.inRd, 7'b0110011};
            5'd10: begin
                word  = {bus.inImm[11:0], bus.inRs1, 3'b000, bus.inRd, 7'b0010011};
                legal = i_ok;
            end
            5'd11: begin
                word  = {bus.inImm[11:0], bus.inRs1, 3'b010, bus.inRd, 7'b0000011};
                legal = i_ok;
            end
            5'd12: begin
                word  = {bus.inImm[11:5], bus.inRs2, bus.inRs1, 3'b010, bus.inImm[4:0],
                         7'b0100011};
                legal = i_ok;
            end
            5'd13, 5'd14: begin
                word  = {bus.inImm[12], bus.inImm[10:5], bus.inRs2, bus.inRs1,
                         2'b00, bus.inOp == 5'd14, bus.inImm[4:1], bus.inImm[11], 7'b1100011};
                legal = b_ok;
            end
            5'd15: begin
                word  = {bus.inImm[20], bus.inImm[10:1], bus.inImm[11], bus.inImm[19:12],
                         bus.inRd, 7'b1101111};
                legal = j_ok;
            end
            5'd16: begin
                word  = {bus.inImm[11:0], bus.inRs1, 3'b000, bus.inRd, 7'b1100111};
                legal = i_ok;
            end
            5'd17: word = {bus.inImm[31:12], bus.inRd, 7'b0110111};
            5'd18: begin
                word  = {li_hi, bus.inRd, 7'b0110111};
                is_li = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q & ~xfer;
        instr_d = instr_q;
        pend_d  = pend_q;
        err_d   = err_q;
        addr_d  = xfer ? addr_q + ADDR_WIDTH'(1) : addr_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (legal) begin
                        valid_d = 1'b1;
                        instr_d = word;
                        if (is_li) begin
                            pend_d  = li_lo;
                            state_d = StLiLo;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLiLo: begin
                if (xfer) begin
                    valid_d = 1'b1;
                    instr_d = pend_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            instr_q <= '0;
            pend_q  <= '0;
            addr_q  <= ADDR_WIDTH'(BASE_ADDR);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign bus.inReady        = in_ready;
    assign bus.outValid       = valid_q;
    assign bus.outInstruction = instr_q;
    assign bus.outAddress     = addr_q;
    assign bus.errorFlag      = err_q;
endmodule

// File: tb/tb_riscv_instruction_encoder.sv
// Directed-vector bench for riscv_instruction_encoder: default instance for encoding and
// handshake, a 2-bit-address instance for wrap and reset-during-LI.
module tb_riscv_instruction_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    riscv_instruction_encoder_if #(.ADDR_WIDTH(10)) b ();
    riscv_instruction_encoder_if #(.ADDR_WIDTH(2))  b2 ();

    riscv_instruction_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .bus(b)
    );
    riscv_instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_dut2 (
        .clk(clk), .rst(rst2), .bus(b2)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        b.inValid = 1'b0;
        b.outReady = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one op at a negedge; returns 1ns after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        @(negedge clk);
        b.inOp = op; b.inRd = rd; b.inRs1 = rs1; b.inRs2 = rs2; b.inImm = imm;
        b.inValid = 1'b1;
        @(posedge clk);
        #1;
        b.inValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (b.outValid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", b.outValid); end
        checks++; if (b.outInstruction !== 32'h0) begin errors++;
            $display("FAIL reset_instr got %h want 00000000", b.outInstruction); end
        checks++; if (b.outAddress !== 10'd0) begin errors++;
            $display("FAIL reset_addr got %0d want 0", b.outAddress); end
        checks++; if (b.errorFlag !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b want 0", b.errorFlag); end
        checks++; if (b.inReady !== 1'b1) begin errors++;
            $display("FAIL reset_ready got %b want 1", b.inReady); end
    endtask

    task automatic test_addi();
        do_reset();
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'd5);
        checks++; if (b.outValid !== 1'b1 || b.outInstruction !== 32'h00500093) begin errors++;
            $display("FAIL addi5 got %b/%h want 1/00500093", b.outValid, b.outInstruction); end
        checks++; if (b.outAddress !== 10'd0) begin errors++;
            $display("FAIL addi5_addr got %0d want 0", b.outAddress); end
        issue(5'd10, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF);
        checks++; if (b.outInstruction !== 32'hFFF00113 || b.outAddress !== 10'd1) begin
            errors++;
            $display("FAIL addi_m1 got %h@%0d want fff00113@1", b.outInstruction, b.outAddress);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        checks++; if (b.outInstruction !== 32'h002081B3 || b.outAddress !== 10'd0) begin
            errors++;
            $display("FAIL b2b_add got %h@%0d want 002081b3@0", b.outInstruction, b.outAddress);
        end
        issue(5'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        checks++; if (b.outInstruction !== 32'h402081B3 || b.outAddress !== 10'd1) begin
            errors++;
            $display("FAIL b2b_sub got %h@%0d want 402081b3@1", b.outInstruction, b.outAddress);
        end
    endtask

    task automatic test_li();
        do_reset();
        issue(5'd18, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        checks++; if (b.outInstruction !== 32'h123462B7 || b.outAddress !== 10'd0) begin
            errors++;
            $display("FAIL li_lui got %h@%0d want 123462b7@0", b.outInstruction, b.outAddress);
        end
        checks++; if (b.inReady !== 1'b0) begin errors++;
            $display("FAIL li_ready got %b want 0", b.inReady); end
        @(posedge clk); #1;
        checks++; if (b.outValid !== 1'b1 || b.outInstruction !== 32'hFFF28293
                      || b.outAddress !== 10'd1) begin errors++;
            $display("FAIL li_addi got %h@%0d want fff28293@1", b.outInstruction, b.outAddress);
        end
        checks++; if (b.inReady !== 1'b1) begin errors++;
            $display("FAIL li_ready_back got %b want 1", b.inReady); end
        issue(5'd18, 5'd1, 5'd0, 5'd0, 32'h00000800);
        checks++; if (b.outInstruction !== 32'h000010B7 || b.outAddress !== 10'd2) begin
            errors++;
            $display("FAIL li800_lui got %h@%0d want 000010b7@2", b.outInstruction, b.outAddress);
        end
        @(posedge clk); #1;
        checks++; if (b.outInstruction !== 32'h80008093 || b.outAddress !== 10'd3) begin
            errors++;
            $display("FAIL li800_addi got %h@%0d want 80008093@3", b.outInstruction, b.outAddress);
        end
    endtask

    task automatic test_branch();
        do_reset();
        issue(5'd13, 5'd0, 5'd1, 5'd2, 32'd8);
        checks++; if (b.outInstruction !== 32'h00208463 || b.outAddress !== 10'd0) begin
            errors++;
            $display("FAIL beq8 got %h@%0d want 00208463@0", b.outInstruction, b.outAddress);
        end
        @(posedge clk); #1;
        issue(5'd13, 5'd0, 5'd1, 5'd2, 32'd7);
        checks++; if (b.outValid !== 1'b0 || b.outAddress !== 10'd1 || b.errorFlag !== 1'b1)
        begin errors++;
            $display("FAIL beq7 got v%b a%0d e%b want v0 a1 e1", b.outValid, b.outAddress,
                     b.errorFlag);
        end
        issue(5'd14, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        checks++; if (b.outInstruction !== 32'hFE209EE3 || b.outAddress !== 10'd1) begin
            errors++;
            $display("FAIL bne_m4 got %h@%0d want fe209ee3@1", b.outInstruction, b.outAddress);
        end
    endtask

    task automatic test_formats();
        logic [4:0]  ops [7] = '{5'd12, 5'd15, 5'd17, 5'd11, 5'd16, 5'd7, 5'd9};
        logic [4:0]  rds [7] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd0, 5'd3, 5'd3};
        logic [4:0]  r1s [7] = '{5'd2, 5'd0, 5'd0, 5'd2, 5'd1, 5'd1, 5'd1};
        logic [4:0]  r2s [7] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd2};
        logic [31:0] imms[7] = '{32'hFFFFFFFC, 32'd8, 32'hABCDE123, 32'd16, 32'd0, 32'd0, 32'd0};
        logic [31:0] exps[7] = '{32'hFE312E23, 32'h008000EF, 32'hABCDE137, 32'h01012283,
                                 32'h00008067, 32'h4020D1B3, 32'h0020F1B3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], rds[i], r1s[i], r2s[i], imms[i]);
            checks++;
            if (b.outInstruction !== exps[i] || b.outAddress !== 10'(i)) begin errors++;
                $display("FAIL format_%0d got %h@%0d want %h@%0d", i, b.outInstruction,
                         b.outAddress, exps[i], i);
            end
        end
        checks++; if (b.errorFlag !== 1'b0) begin errors++;
            $display("FAIL format_err got %b want 0", b.errorFlag); end
    endtask

    task automatic test_errors();
        do_reset();
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'd2047);
        checks++; if (b.outInstruction !== 32'h7FF00093 || b.errorFlag !== 1'b0) begin errors++;
            $display("FAIL imm2047 got %h e%b want 7ff00093 e0", b.outInstruction, b.errorFlag);
        end
        @(posedge clk); #1;
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
        checks++; if (b.outInstruction !== 32'h80000093 || b.errorFlag !== 1'b0) begin errors++;
            $display("FAIL imm_m2048 got %h e%b want 80000093 e0", b.outInstruction, b.errorFlag);
        end
        @(posedge clk); #1;
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
        checks++; if (b.outValid !== 1'b0 || b.outAddress !== 10'd2 || b.errorFlag !== 1'b1)
        begin errors++;
            $display("FAIL imm2048 got v%b a%0d e%b want v0 a2 e1", b.outValid, b.outAddress,
                     b.errorFlag);
        end
        do_reset();
        issue(5'd19, 5'd1, 5'd0, 5'd0, 32'd0);
        checks++; if (b.outValid !== 1'b0 || b.errorFlag !== 1'b1) begin errors++;
            $display("FAIL illegal_op got v%b e%b want v0 e1", b.outValid, b.errorFlag); end
        do_reset();
        issue(5'd15, 5'd1, 5'd0, 5'd0, 32'h00100000);
        checks++; if (b.outValid !== 1'b0 || b.errorFlag !== 1'b1) begin errors++;
            $display("FAIL jal_range got v%b e%b want v0 e1", b.outValid, b.errorFlag); end
        issue(5'd10, 5'd1, 5'd0, 5'd0, 32'd1);
        checks++; if (b.outValid !== 1'b1 || b.errorFlag !== 1'b1 || b.outAddress !== 10'd0)
        begin errors++;
            $display("FAIL err_sticky got v%b e%b a%0d want v1 e1 a0", b.outValid, b.errorFlag,
                     b.outAddress);
        end
        do_reset();
        checks++; if (b.errorFlag !== 1'b0) begin errors++;
            $display("FAIL err_clear got %b want 0", b.errorFlag); end
    endtask

    task automatic test_backpressure();
        do_reset();
        b.outReady = 1'b0;
        issue(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        b.inOp = 5'd1; b.inValid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (b.outValid !== 1'b1 || b.outInstruction !== 32'h002081B3
                || b.outAddress !== 10'd0 || b.inReady !== 1'b0) begin errors++;
                $display("FAIL stall got v%b %h@%0d r%b want v1 002081b3@0 r0", b.outValid,
                         b.outInstruction, b.outAddress, b.inReady);
            end
        end
        @(negedge clk);
        b.inValid = 1'b0;
        b.outReady = 1'b1;
        @(posedge clk); #1;
        checks++; if (b.outValid !== 1'b0 || b.outAddress !== 10'd1) begin errors++;
            $display("FAIL release got v%b a%0d want v0 a1", b.outValid, b.outAddress); end
        @(posedge clk); #1;
        checks++; if (b.outAddress !== 10'd1) begin errors++;
            $display("FAIL release_once got a%0d want a1", b.outAddress); end
    endtask

    task automatic test_wrap_and_li_reset();
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b2.inOp = 5'd10; b2.inRd = 5'd1; b2.inRs1 = 5'd0; b2.inRs2 = 5'd0;
            b2.inImm = 32'(i); b2.inValid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (b2.outValid !== 1'b1 || b2.outAddress !== 2'(i % 4)) begin errors++;
                $display("FAIL wrap_%0d got v%b a%0d want v1 a%0d", i, b2.outValid,
                         b2.outAddress, i % 4);
            end
        end
        @(negedge clk);
        b2.inValid = 1'b0;
        @(negedge clk);
        b2.outReady = 1'b0;
        b2.inOp = 5'd18; b2.inRd = 5'd5; b2.inImm = 32'h12345FFF; b2.inValid = 1'b1;
        @(posedge clk); #1;
        b2.inValid = 1'b0;
        checks++; if (b2.inReady !== 1'b0 || b2.outInstruction !== 32'h123462B7
                      || b2.outAddress !== 2'd1) begin errors++;
            $display("FAIL li_held got r%b %h@%0d want r0 123462b7@1", b2.inReady,
                     b2.outInstruction, b2.outAddress);
        end
        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk); #1;
        checks++; if (b2.outValid !== 1'b0 || b2.outInstruction !== 32'h0
                      || b2.outAddress !== 2'd0 || b2.inReady !== 1'b1) begin errors++;
            $display("FAIL li_rst got v%b %h@%0d r%b want v0 00000000@0 r1", b2.outValid,
                     b2.outInstruction, b2.outAddress, b2.inReady);
        end
        @(negedge clk);
        rst2 = 1'b0;
        b2.outReady = 1'b1;
        @(posedge clk); #1;
        checks++; if (b2.outValid !== 1'b0 || b2.outAddress !== 2'd0) begin errors++;
            $display("FAIL li_drop got v%b a%0d want v0 a0", b2.outValid, b2.outAddress); end
    endtask

    initial begin
        b.inValid = 1'b0; b.inOp = '0; b.inRd = '0; b.inRs1 = '0; b.inRs2 = '0;
        b.inImm = '0; b.outReady = 1'b1;
        b2.inValid = 1'b0; b2.inOp = '0; b2.inRd = '0; b2.inRs1 = '0; b2.inRs2 = '0;
        b2.inImm = '0; b2.outReady = 1'b1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_li();
        test_branch();
        test_formats();
        test_errors();
        test_backpressure();
        test_wrap_and_li_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
